// File: rtl/sensor_trace_buffer.sv
// Triggered trace capture of decoder samples with valid/ready readback.
// Define SENSOR_TRACE_ACCUM_EN to store sums of 2**ACC_LOG2 samples per word.
module sensor_trace_buffer #(
  parameter int unsigned SAMPLE_WIDTH = 7,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned ACC_LOG2     = 2
) (
  input  logic                             clkin,
  input  logic                             rstin,
  input  logic [SAMPLE_WIDTH-1:0]          sample_in,
  input  logic                             arm,
  input  logic                             trigger,
  input  logic                             abort,
  input  logic                             rd_ready,
  output logic [SAMPLE_WIDTH+ACC_LOG2-1:0] rd_data,
  output logic                             rd_valid,
  output logic                             rd_last,
  output logic                             armed,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned WordWidth = SAMPLE_WIDTH + ACC_LOG2;
  localparam int unsigned Depth     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StRead} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] waddr_q, raddr_q;
  logic                  wr_en;
  logic [WordWidth-1:0]  wr_data;
  logic                  cap_last;
  logic                  xfer;
  logic                  load;
  logic                  ph_q;

  logic [WordWidth-1:0] mem [Depth];

`ifdef SENSOR_TRACE_ACCUM_EN
  localparam int unsigned AccCount = 2 ** ACC_LOG2;
  localparam logic [ACC_LOG2:0] SubMax = (ACC_LOG2 + 1)'(AccCount - 1);

  logic [ACC_LOG2:0]    sub_q;
  logic [WordWidth-1:0] acc_q, acc_sum;

  assign acc_sum = acc_q + WordWidth'(sample_in);
  assign wr_en   = (state_q == StCapture) && (sub_q == SubMax);
  assign wr_data = acc_sum;

  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      sub_q <= '0;
      acc_q <= '0;
    end else if (state_q == StArmed) begin
      sub_q <= '0;
      acc_q <= '0;
    end else if (state_q == StCapture) begin
      if (sub_q == SubMax) begin
        sub_q <= '0;
        acc_q <= '0;
      end else begin
        sub_q <= sub_q + (ACC_LOG2 + 1)'(1);
        acc_q <= acc_sum;
      end
    end
  end
`else
  assign wr_en   = (state_q == StCapture);
  assign wr_data = WordWidth'(sample_in);
`endif

  assign cap_last = wr_en && (waddr_q == LastAddr);
  assign xfer     = rd_valid && rd_ready;
  // First READ cycle only primes ph_q, giving the one-cycle read latency.
  assign load     = (state_q == StRead) && !rd_valid && ph_q;

  assign armed = (state_q == StArmed);
  assign busy  = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (arm)              state_d = StArmed;
      StArmed:   if (trigger)          state_d = StCapture;
      StCapture: if (cap_last)         state_d = StRead;
      StRead:    if (xfer && rd_last)  state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clkin) begin
    if (wr_en) mem[waddr_q] <= wr_data;
  end

  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      waddr_q  <= '0;
      raddr_q  <= '0;
      ph_q     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (state_q == StArmed)  waddr_q <= '0;
      else if (wr_en)          waddr_q <= waddr_q + ADDR_WIDTH'(1);

      if (state_q == StCapture) raddr_q <= '0;
      else if (xfer)            raddr_q <= raddr_q + ADDR_WIDTH'(1);

      ph_q <= (state_q == StRead);

      if (load) rd_data <= mem[raddr_q];

      if (abort) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end else if (load) begin
        rd_valid <= 1'b1;
        rd_last  <= (raddr_q == LastAddr);
      end else if (xfer) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end

      done <= xfer && rd_last && !abort;
    end
  end

endmodule

// File: tb/tb_sensor_trace_buffer.sv
// Directed bench for sensor_trace_buffer with ADDR_WIDTH=4 (16-word trace).
module tb_sensor_trace_buffer;

  localparam int SW    = 7;
  localparam int AW    = 4;
  localparam int AL    = 2;
  localparam int WW    = SW + AL;
  localparam int DEPTH = 2 ** AW;
`ifdef SENSOR_TRACE_ACCUM_EN
  localparam int ACCN = 2 ** AL;
`else
  localparam int ACCN = 1;
`endif
  localparam int CAPLEN = DEPTH * ACCN;

  logic          clkin = 1'b0;
  logic          rstin;
  logic [SW-1:0] sample_in;
  logic          arm, trigger, abort, rd_ready;
  logic [WW-1:0] rd_data;
  logic          rd_valid, rd_last, armed, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  sensor_trace_buffer #(
    .SAMPLE_WIDTH(SW),
    .ADDR_WIDTH  (AW),
    .ACC_LOG2    (AL)
  ) dut (
    .clkin    (clkin),
    .rstin    (rstin),
    .sample_in(sample_in),
    .arm      (arm),
    .trigger  (trigger),
    .abort    (abort),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_last  (rd_last),
    .armed    (armed),
    .busy     (busy),
    .done     (done)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic arm;
    logic trigger;
    logic abort;
    logic exp_armed;
    logic exp_busy;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sample_at(input int j, input int mul, input int add);
    return (mul * j + add) % 128;
  endfunction

  function automatic int exp_word(input int i, input int mul, input int add);
    int s;
    s = 0;
    for (int k = 0; k < ACCN; k++) s += sample_at(i * ACCN + k, mul, add);
    return s;
  endfunction

  // Arm, trigger and feed CAPLEN samples; returns after the edge of the last write.
  task automatic do_capture(input int mul, input int add);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("armed_wait", armed, 1);
    trigger   = 1'b1;
    sample_in = 7'd127;
    tick();
    trigger = 1'b0;
    check("armed_after_trig", armed, 0);
    for (int j = 0; j < CAPLEN; j++) begin
      sample_in = SW'(sample_at(j, mul, add));
      if (j == CAPLEN - 1) check("busy_in_capture", busy, 1);
      tick();
    end
    sample_in = '0;
    check("valid_low_t+N", rd_valid, 0);
    tick();
    check("valid_low_t+N+1", rd_valid, 0);
  endtask

  task automatic do_read(input int mul, input int add, input bit rnd, input int abort_at);
    logic [WW-1:0] held;
    int            stalls;
    rd_ready = 1'b0;
    tick();
    check("first_valid_t+N+2", rd_valid, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("valid[%0d]", i), rd_valid, 1);
      check($sformatf("data[%0d]", i), rd_data, exp_word(i, mul, add));
      check($sformatf("last[%0d]", i), rd_last, (i == DEPTH - 1) ? 1 : 0);
      held   = rd_data;
      stalls = 0;
      while (rnd && stalls < 4 && $urandom_range(0, 2) == 0) begin
        rd_ready = 1'b0;
        tick();
        stalls++;
        check($sformatf("stall_data[%0d]", i), rd_data, held);
        check($sformatf("stall_valid[%0d]", i), rd_valid, 1);
      end
      if (i == abort_at) begin
        abort    = 1'b1;
        rd_ready = 1'b1;
        tick();
        abort    = 1'b0;
        rd_ready = 1'b0;
        check("abort_valid", rd_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick();
        check("abort_done_later", done, 0);
        check("abort_valid_later", rd_valid, 0);
        return;
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      if (i == DEPTH - 1) begin
        check("done_pulse", done, 1);
        check("busy_fall", busy, 0);
        check("valid_after_last", rd_valid, 0);
        tick();
        check("done_one_cycle", done, 0);
      end else begin
        check($sformatf("gap[%0d]", i), rd_valid, 0);
        tick();
      end
    end
  endtask

  initial begin
    rstin     = 1'b1;
    sample_in = '0;
    arm       = 1'b0;
    trigger   = 1'b0;
    abort     = 1'b0;
    rd_ready  = 1'b0;

    //         arm   trig  abort exp_armed exp_busy
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // trigger ignored in IDLE
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};  // abort beats arm
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};  // abort beats trigger
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};  // arm ignored in CAPTURE
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    #12;
    check("rst_data", rd_data, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_last", rd_last, 0);
    check("rst_armed", armed, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clkin);
    rstin = 1'b0;
    tick();

    for (int v = 0; v < 10; v++) begin
      arm     = vecs[v].arm;
      trigger = vecs[v].trigger;
      abort   = vecs[v].abort;
      tick();
      check($sformatf("ctl[%0d].armed", v), armed, int'(vecs[v].exp_armed));
      check($sformatf("ctl[%0d].busy", v), busy, int'(vecs[v].exp_busy));
      check($sformatf("ctl[%0d].valid", v), rd_valid, 0);
    end
    arm     = 1'b0;
    trigger = 1'b0;
    abort   = 1'b0;

    // Asynchronous reset mid-capture.
    arm = 1'b1;
    tick();
    arm     = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (3) tick();
    #2 rstin = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_armed", armed, 0);
    check("midrst_valid", rd_valid, 0);
    check("midrst_data", rd_data, 0);
    @(negedge clkin);
    rstin = 1'b0;
    tick();

    do_capture(1, 0);
    do_read(1, 0, 1'b0, -1);

    do_capture(37, 5);
    do_read(37, 5, 1'b1, -1);

    do_capture(1, 0);
    do_read(1, 0, 1'b0, 5);

    do_capture(0, 64);
    do_read(0, 64, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule
